// File: rtl/sar_adc_pkg.sv
// sar_adc_pkg: shared types and width helpers for the SAR ADC controller.
// Optional free-running mode is enabled with macro SAR_ADC_AUTO_EN.
package sar_adc_pkg;

  localparam int NBITS_DEF         = 10;
  localparam int SAMPLE_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAMPLE,
    S_CONVERT,
    S_DONE
  } state_t;

  function automatic int cnt_w(input int cycles);
    return (cycles > 0) ? $clog2(cycles + 1) : 1;
  endfunction

  function automatic int idx_w(input int nbits);
    return (nbits > 1) ? $clog2(nbits) : 1;
  endfunction

endpackage

// File: rtl/sar_adc_reg.sv
// sar_adc_reg: successive-approximation register holding the bit index,
// partial result and trial DAC code.
module sar_adc_reg
  import sar_adc_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             load,
  input  logic             step,
  input  logic             cmp,
  output logic [NBITS-1:0] code,
  output logic [NBITS-1:0] resolved,
  output logic             last
);

  localparam int IW = idx_w(NBITS);
  localparam logic [NBITS-1:0] ONE = NBITS'(1);

  logic [IW-1:0]    idx;
  logic [NBITS-1:0] res;
  logic [NBITS-1:0] bit_i;
  logic [NBITS-1:0] res_nxt;

  assign bit_i    = ONE << idx;
  assign res_nxt  = cmp ? (res | bit_i) : res;
  assign resolved = res_nxt;
  assign last     = (idx == '0);

  // Lower result bits are always zero here, so OR-ing in the next
  // trial bit yields the kept prefix, next bit set, rest cleared.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx  <= '0;
      res  <= '0;
      code <= '0;
    end else if (clr) begin
      idx  <= '0;
      res  <= '0;
      code <= '0;
    end else if (load) begin
      idx  <= IW'(NBITS - 1);
      res  <= '0;
      code <= ONE << (NBITS - 1);
    end else if (step) begin
      res <= res_nxt;
      if (last) begin
        code <= '0;
      end else begin
        code <= res_nxt | (bit_i >> 1);
        idx  <= idx - 1'b1;
      end
    end
  end

endmodule

// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: track/hold, SAR conversion sequencing and result strobe.
// Define SAR_ADC_AUTO_EN to add the AUTO free-running input.
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int NBITS         = NBITS_DEF,
  parameter int SAMPLE_CYCLES = SAMPLE_CYCLES_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PD,
  input  logic             START,
`ifdef SAR_ADC_AUTO_EN
  input  logic             AUTO,
`endif
  input  logic             CMP,
  output logic             SAMPLE,
  output logic [NBITS-1:0] DAC_CODE,
  output logic [NBITS-1:0] DATAOUT,
  output logic             VALID,
  output logic             BUSY
);

  localparam int CW = cnt_w(SAMPLE_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SAMPLE_CYCLES - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             load;
  logic             step;
  logic             last;
  logic             auto_go;
  logic [NBITS-1:0] resolved;

`ifdef SAR_ADC_AUTO_EN
  assign auto_go = AUTO;
`else
  assign auto_go = 1'b0;
`endif

  assign load = !PD && (state == S_SAMPLE) && (cnt == '0);
  assign step = !PD && (state == S_CONVERT);
  assign BUSY = (state != S_IDLE);

  sar_adc_reg #(
    .NBITS(NBITS)
  ) u_reg (
    .CLK     (CLK),
    .RST     (RST),
    .clr     (PD),
    .load    (load),
    .step    (step),
    .cmp     (CMP),
    .code    (DAC_CODE),
    .resolved(resolved),
    .last    (last)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      cnt     <= '0;
      SAMPLE  <= 1'b0;
      VALID   <= 1'b0;
      DATAOUT <= '0;
    end else if (PD) begin
      state  <= S_IDLE;
      cnt    <= '0;
      SAMPLE <= 1'b0;
      VALID  <= 1'b0;
    end else begin
      VALID <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (START) begin
            state  <= S_SAMPLE;
            SAMPLE <= 1'b1;
            cnt    <= CNT_LOAD;
          end
        end
        S_SAMPLE: begin
          if (cnt == '0) begin
            state  <= S_CONVERT;
            SAMPLE <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_CONVERT: begin
          if (last) begin
            state   <= S_DONE;
            VALID   <= 1'b1;
            DATAOUT <= resolved;
          end
        end
        S_DONE: begin
          if (auto_go) begin
            state  <= S_SAMPLE;
            SAMPLE <= 1'b1;
            cnt    <= CNT_LOAD;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb_sar_adc_ctrl: vector table plus corner sequences for sar_adc_ctrl,
// scoreboarded on VALID; covers SAR_ADC_AUTO_EN when defined.
module tb_sar_adc_ctrl;

  localparam int NB = 10;

  typedef struct {
    logic [NB-1:0] vin;
    logic [NB-1:0] dout;
  } vec_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          PD = 1'b0;
  logic          START = 1'b0;
  logic          AUTO = 1'b0;
  logic          CMP;
  logic          SAMPLE;
  logic [NB-1:0] DAC_CODE;
  logic [NB-1:0] DATAOUT;
  logic          VALID;
  logic          BUSY;

  logic [NB-1:0] vin = '0;
  logic [NB-1:0] sb[$];
  logic [NB-1:0] dac_seen[10];
  int            n_vec = 0;
  int            n_err = 0;
  int            n_valid = 0;

  assign CMP = (vin >= DAC_CODE);

  sar_adc_ctrl dut (
    .CLK     (CLK),
    .RST     (RST),
    .PD      (PD),
    .START   (START),
`ifdef SAR_ADC_AUTO_EN
    .AUTO    (AUTO),
`endif
    .CMP     (CMP),
    .SAMPLE  (SAMPLE),
    .DAC_CODE(DAC_CODE),
    .DATAOUT (DATAOUT),
    .VALID   (VALID),
    .BUSY    (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (VALID) begin
      n_valid++;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: got DATAOUT=0x%0h expected no VALID at %0t",
                 DATAOUT, $time);
      end else begin
        check("dataout", int'(DATAOUT), int'(sb.pop_front()));
      end
    end
  end

  // Called at a negedge; START is sampled by the next rising edge.
  task automatic run_conv(input logic [NB-1:0] v, input logic [NB-1:0] exp,
                          input bit extra);
    int c;
    int ns;
    bit got;
    vin = v;
    sb.push_back(exp);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    c = 1;
    ns = 0;
    got = 1'b0;
    while (!got && c <= 40) begin
      if (SAMPLE) ns++;
      if (c >= 5 && c <= 14) dac_seen[c-5] = DAC_CODE;
      START = (extra && (c == 2 || c == 8));
      if (VALID) begin
        got = 1'b1;
      end else begin
        @(negedge CLK);
        c++;
      end
    end
    START = 1'b0;
    check("latency", c, 15);
    check("sample_len", ns, 4);
    @(negedge CLK);
    check("busy_low", int'(BUSY), 0);
  endtask

  vec_t tbl[8];
  logic [NB-1:0] exp_dac[10];

  initial begin
    int v0;
    int t1;
    int t2;
    int t3;
    int nv;

    tbl[0] = '{10'h2A5, 10'h2A5};
    tbl[1] = '{10'h000, 10'h000};
    tbl[2] = '{10'h3FF, 10'h3FF};
    tbl[3] = '{10'h200, 10'h200};
    tbl[4] = '{10'h1FF, 10'h1FF};
    tbl[5] = '{10'h3FE, 10'h3FE};
    tbl[6] = '{10'h001, 10'h001};
    tbl[7] = '{10'h0F0, 10'h0F0};
    exp_dac = '{10'h200, 10'h300, 10'h280, 10'h2C0, 10'h2A0,
                10'h2B0, 10'h2A8, 10'h2A4, 10'h2A6, 10'h2A5};

    repeat (2) @(negedge CLK);
    check("rst_sample", int'(SAMPLE), 0);
    check("rst_dac", int'(DAC_CODE), 0);
    check("rst_dataout", int'(DATAOUT), 0);
    check("rst_valid", int'(VALID), 0);
    check("rst_busy", int'(BUSY), 0);
    RST = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 8; i++) begin
      v0 = n_valid;
      run_conv(tbl[i].vin, tbl[i].dout, 1'b0);
      check("one_valid", n_valid - v0, 1);
      if (i == 0)
        for (int j = 0; j < 10; j++)
          check("dac_seq", int'(dac_seen[j]), int'(exp_dac[j]));
      @(negedge CLK);
    end

    // abort: 0x0F0 is the prior result from the last table vector
    vin = 10'h155;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (6) @(negedge CLK);
    PD = 1'b1;
    @(negedge CLK);
    check("pd_busy", int'(BUSY), 0);
    check("pd_dac", int'(DAC_CODE), 0);
    check("pd_sample", int'(SAMPLE), 0);
    check("pd_valid", int'(VALID), 0);
    check("pd_dataout", int'(DATAOUT), 10'h0F0);
    START = 1'b1;
    repeat (3) @(negedge CLK);
    check("pd_over_start", int'(BUSY), 0);
    START = 1'b0;
    PD = 1'b0;
    v0 = n_valid;
    repeat (20) @(negedge CLK);
    check("pd_no_valid", n_valid - v0, 0);
    run_conv(10'h155, 10'h155, 1'b0);
    @(negedge CLK);

    // extra START pulses while busy
    v0 = n_valid;
    run_conv(10'h2A5, 10'h2A5, 1'b1);
    repeat (25) @(negedge CLK);
    check("busy_one_valid", n_valid - v0, 1);

    // START held high: back-to-back with one idle cycle
    vin = 10'h1FF;
    repeat (3) sb.push_back(10'h1FF);
    START = 1'b1;
    nv = 0;
    t1 = 0;
    t2 = 0;
    t3 = 0;
    for (int t = 0; t < 80 && nv < 3; t++) begin
      @(negedge CLK);
      if (VALID) begin
        nv++;
        if (nv == 1) t1 = t;
        if (nv == 2) t2 = t;
        if (nv == 3) begin
          t3 = t;
          START = 1'b0;
        end
      end
    end
    START = 1'b0;
    check("held_count", nv, 3);
    check("held_period1", t2 - t1, 16);
    check("held_period2", t3 - t2, 16);
    repeat (20) @(negedge CLK);
    check("held_idle", int'(BUSY), 0);

    // asynchronous reset mid-CONVERT
    vin = 10'h2A5;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (7) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check("arst_sample", int'(SAMPLE), 0);
    check("arst_dac", int'(DAC_CODE), 0);
    check("arst_dataout", int'(DATAOUT), 0);
    check("arst_valid", int'(VALID), 0);
    check("arst_busy", int'(BUSY), 0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    run_conv(10'h001, 10'h001, 1'b0);
    @(negedge CLK);

`ifdef SAR_ADC_AUTO_EN
    AUTO = 1'b1;
    vin = 10'h100;
    sb.push_back(10'h100);
    sb.push_back(10'h200);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    nv = 0;
    t1 = 0;
    t2 = 0;
    for (int t = 0; t < 60 && nv < 2; t++) begin
      @(negedge CLK);
      if (VALID) begin
        nv++;
        if (nv == 1) begin
          t1 = t;
          vin = 10'h200;
        end else begin
          t2 = t;
          AUTO = 1'b0;
        end
      end
    end
    AUTO = 1'b0;
    check("auto_count", nv, 2);
    check("auto_period", t2 - t1, 15);
    repeat (20) @(negedge CLK);
`endif

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sar_adc_ctrl.md
Name: sar_adc_ctrl

Overview:
Digital successive-approximation controller forming the ADC counterpart of the team's current-steering DAC model.
- Sequences track/hold, drives a trial code into the internal capacitive/current DAC, and samples a single comparator bit per step.
- Delivers an N-bit conversion result with a valid strobe.
- Sits between the analog front end (S/H, DAC array, comparator) and the SoC peripheral register interface.

Parameters:
NBITS, 10, resolution of result and trial DAC code
SAMPLE_CYCLES, 4, CLK cycles SAMPLE is held high for acquisition (legal range 1..255)

Ports:
CLK  input  1  conversion clock, rising edge
RST  input  1  asynchronous active-high reset
PD  input  1  power-down; synchronous abort to IDLE while high
START  input  1  request one conversion; sampled only in IDLE
CMP  input  1  comparator result, valid at every rising edge during CONVERT: 1 = Vin >= Vdac(DAC_CODE)
SAMPLE  output  1  track/hold control, 1 = track
DAC_CODE  output  NBITS  trial code to internal DAC
DATAOUT  output  NBITS  last completed result, held until next completion
VALID  output  1  one-cycle pulse when DATAOUT updates
BUSY  output  1  high in any state other than IDLE

Behaviour:
Reset and power-down:
- RST high: state IDLE; SAMPLE=0, DAC_CODE=0, DATAOUT=0, VALID=0, BUSY=0; sample counter and bit index cleared.
- PD high in any state: next edge forces IDLE; DAC_CODE=0, SAMPLE=0, VALID=0.
- On PD abort, DATAOUT keeps its previous value and no VALID is issued.
- PD overrides START.

States: IDLE -> SAMPLE -> CONVERT -> DONE -> IDLE.

IDLE:
- START=1 and PD=0 -> SAMPLE.
- Load sample counter with SAMPLE_CYCLES-1.

SAMPLE:
- SAMPLE output=1 for exactly SAMPLE_CYCLES cycles. Counter decrements; at 0 -> CONVERT.
- Bit index = NBITS-1; DAC_CODE = 1<<(NBITS-1) (mid-scale), registered on that transition.

CONVERT (one cycle per bit, MSB first):
- At edge ending trial of bit i: result[i] = CMP.
- If i>0, DAC_CODE = result[NBITS-1:i] kept, bit i-1 set, lower bits 0.
- After bit 0 is resolved -> DONE.
- Exactly NBITS cycles in CONVERT.

DONE:
- DATAOUT <= resolved result; VALID=1 for this single cycle; DAC_CODE=0.
- Next state IDLE.

Timing and handshake:
- Latency: START sampled at edge k -> VALID high in cycle k+SAMPLE_CYCLES+NBITS+1.
- START while BUSY is ignored (no queueing).
- START held high continuously gives back-to-back conversions with one IDLE cycle between DONE and the next SAMPLE.

Widths and boundaries:
- All code arithmetic is unsigned NBITS; no carries.
- Vin below the LSB threshold -> 0; Vin at or above full scale -> all ones (2^NBITS-1).

Optional Feature:
Macro SAR_ADC_AUTO_EN.
- Defined: adds input AUTO (1 bit). AUTO=1 with PD=0 makes DONE go directly to SAMPLE, so conversions are free-running with no IDLE gap. AUTO=0 behaves as undefined build; START is still honoured in IDLE.
- Not defined: no AUTO port; DONE always returns to IDLE.

Decomposition:
- Package sar_adc_pkg holds: state enum type (IDLE, SAMPLE, CONVERT, DONE) and localparam widths derived from NBITS and SAMPLE_CYCLES (counter width = clog2(SAMPLE_CYCLES+1)).
- One natural sub-module: sar_adc_reg (successive-approximation shift/mask register). Holds bit index and result, and generates DAC_CODE from CMP, under load/step enables from the FSM in sar_adc_ctrl.

Test Plan:
- Bench model: CMP = (VIN_CODE >= DAC_CODE) evaluated on the current DAC_CODE.
- Defaults, VIN_CODE=0x2A5, START pulse at edge k -> SAMPLE high 4 cycles; DAC_CODE sequence 0x200, 0x300, 0x280, 0x2C0, 0x2A0, 0x2B0, 0x2A8, 0x2A4, 0x2A6, 0x2A5; VALID at k+15 with DATAOUT=0x2A5; BUSY low at k+16.
- Boundaries, VIN_CODE=0 -> DATAOUT=0x000; VIN_CODE=0x3FF -> DATAOUT=0x3FF, each with a single VALID pulse.
- Abort, PD raised during 3rd CONVERT cycle of a 0x155 conversion after a prior result 0x0F0 -> IDLE next edge, no VALID, DATAOUT stays 0x0F0, DAC_CODE=0; START after PD low converts normally to 0x155.
- Busy, extra START pulses during SAMPLE and CONVERT -> ignored, exactly one VALID. START held high -> VALID every 16 cycles.
- Reset, RST asserted asynchronously mid-CONVERT (between edges) -> all outputs 0 immediately; after release, conversion of 0x001 completes with DATAOUT=0x001.
- SAR_ADC_AUTO_EN defined, AUTO=1, VIN_CODE stepping 0x100 then 0x200 -> VALID every 15 cycles with no IDLE gap, DATAOUT 0x100 then 0x200.
